// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter/rotator for WIDTH-bit words.
//
// Shifts or rotates din by shamt. The direction (lr) and the fill mode
// (mode) are chosen per transaction. Each of the SHW = log2(WIDTH) mux
// stages shifts by 2^k. With STAGE_REG=1 every stage is registered, which
// gives a valid/ready streaming pipeline (latency SHW, capacity SHW).
// With STAGE_REG=0 the mux tree is combinational and feeds one output
// register (latency 1, capacity 1).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   input transaction present
//   in_ready   out  block accepts input this cycle (combinational from out_ready)
//   din        in   WIDTH-bit operand
//   shamt      in   SHW-bit shift amount
//   lr         in   0 = right, 1 = left
//   mode       in   00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   out_valid  out  result present
//   out_ready  in   consumer accepts result
//   dout       out  WIDTH-bit result, held while stalled and after out_valid drops
//   inflight   out  number of valid transactions held in the block
module shift_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          STAGE_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     lr,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(WIDTH):0]   inflight
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW:0] ONE = 1;

    typedef enum logic [1:0] {
        MODE_LOGIC  = 2'b00,
        MODE_ARITH  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // One mux stage: shift d by the constant s (s < WIDTH).
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             left,
        input logic [1:0]       md,
        input logic             sgn,
        input int unsigned      s
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        res  = '0;
        if (left) begin
            if (mode_e'(md) == MODE_ROTATE) res = (d << s) | (d >> (WIDTH - s));
            else                            res = d << s;
        end else begin
            case (mode_e'(md))
                MODE_ROTATE: res = (d >> s) | (d << (WIDTH - s));
                MODE_ARITH:  res = (d >> s) | (sgn ? ~(ones >> s) : '0);
                default:     res = d >> s;
            endcase
        end
        return res;
    endfunction

    logic w_in_xfer;
    logic w_out_xfer;

    if (STAGE_REG) begin : g_pipe
        // w_load[k]: stage k register loads this cycle; w_load[SHW] is the consumer.
        logic [SHW:0] w_load;
        assign w_load[SHW] = out_ready;

        for (genvar k = 0; k < SHW; k++) begin : g_stage
            // Only the not-yet-applied shamt bits travel with the data:
            // bit 0 of w_amt is this stage's control bit.
            logic [SHW-k-1:0] w_amt;
            logic [WIDTH-1:0] w_src;
            logic [WIDTH-1:0] w_res;
            logic             w_lr;
            logic             w_sgn;
            logic             w_vld;
            logic [1:0]       w_mode;
            logic [WIDTH-1:0] r_data;
            logic             r_vld;

            if (k == 0) begin : g_first
                assign w_src  = din;
                assign w_amt  = shamt;
                assign w_lr   = lr;
                assign w_mode = mode;
                assign w_sgn  = din[WIDTH-1];
                assign w_vld  = in_valid;
            end else begin : g_next
                assign w_src  = g_stage[k-1].r_data;
                assign w_amt  = g_stage[k-1].g_ctl.r_amt;
                assign w_lr   = g_stage[k-1].g_ctl.r_lr;
                assign w_mode = g_stage[k-1].g_ctl.r_mode;
                assign w_sgn  = g_stage[k-1].g_ctl.r_sgn;
                assign w_vld  = g_stage[k-1].r_vld;
            end

            assign w_res     = w_amt[0] ? shift_step(w_src, w_lr, w_mode, w_sgn, 32'd1 << k) : w_src;
            assign w_load[k] = !r_vld || w_load[k+1];

            // Data only changes when a valid word arrives, so the last
            // stage keeps its value when a bubble moves in behind it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else if (w_load[k]) begin
                    r_vld <= w_vld;
                    if (w_vld) r_data <= w_res;
                end
            end

            // The last stage has no downstream mux, so it keeps no control fields.
            if (k < SHW - 1) begin : g_ctl
                logic [SHW-k-2:0] r_amt;
                logic             r_lr;
                logic             r_sgn;
                logic [1:0]       r_mode;

                always_ff @(posedge clk) begin
                    if (w_load[k] && w_vld) begin
                        r_amt  <= w_amt[SHW-k-1:1];
                        r_lr   <= w_lr;
                        r_sgn  <= w_sgn;
                        r_mode <= w_mode;
                    end
                end
            end
        end

        assign in_ready  = w_load[0];
        assign out_valid = g_stage[SHW-1].r_vld;
        assign dout      = g_stage[SHW-1].r_data;
    end else begin : g_comb
        logic [WIDTH-1:0] w_acc;
        logic [WIDTH-1:0] r_dout;
        logic             r_ovld;
        logic             w_rdy;

        always_comb begin
            w_acc = din;
            for (int unsigned k = 0; k < SHW; k++) begin
                if (shamt[k]) w_acc = shift_step(w_acc, lr, mode, din[WIDTH-1], 32'd1 << k);
            end
        end

        assign w_rdy = !r_ovld || out_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ovld <= 1'b0;
                r_dout <= '0;
            end else if (w_rdy) begin
                r_ovld <= in_valid;
                if (in_valid) r_dout <= w_acc;
            end
        end

        assign in_ready  = w_rdy;
        assign out_valid = r_ovld;
        assign dout      = r_dout;
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    logic [SHW:0] r_inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_inflight <= r_inflight + ONE;
                2'b01:   r_inflight <= r_inflight - ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight = r_inflight;

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised successor to the team's 8-bit mux-tree barrel shifter.
- Shifts or rotates a WIDTH-bit word by a log2(WIDTH)-bit amount. Direction and fill mode are selected per transaction.
- The log2(WIDTH) mux stages can each be registered, giving a streaming pipeline with valid/ready flow control on both sides.
- Sits between an operand source and an ALU/writeback consumer; one transaction per cycle when unstalled.

Parameters:
- WIDTH, 8, data width; power of two, 2..64. SHW = log2(WIDTH) is derived, not overridable.
- STAGE_REG, 1, 1 = pipeline register after every shift stage (latency SHW); 0 = combinational mux tree with one output register (latency 1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept input this cycle
- din  in  WIDTH  operand
- shamt  in  SHW  shift amount
- lr  in  1  0 = shift right, 1 = shift left
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- dout  out  WIDTH  result
- inflight  out  SHW+1  number of valid transactions held in the pipeline

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high on rst, sampled at the rising edge of clk.
  - Reset clears every stage valid bit, dout = 0 and inflight = 0.
  - After reset, in_ready = 1 and out_valid = 0.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage structure:
  - Stage k (k = 0..SHW-1) conditionally shifts by 2^k, controlled by shamt[k].
  - Each stage carries its data, the remaining shamt bits, lr, mode and a valid bit.
- Per-stage advance:
  - Stage register k loads when it is empty or when stage k+1 (or the consumer, for the last stage) accepts this cycle.
  - Otherwise stage k holds all of its fields unchanged.
  - in_ready = the stage-0 load condition. It is combinational from out_ready through the ready chain; no skid buffer.
- Latency:
  - STAGE_REG=1: a result reaches dout SHW cycles after input transfer when unstalled. Capacity is SHW transactions.
  - STAGE_REG=0: latency 1, capacity 1. in_ready = !out_valid || out_ready.
- Throughput and ordering:
  - One transaction per cycle with out_ready held high.
  - Order is preserved. No transaction is dropped or duplicated under any stall pattern.
- Arithmetic rules:
  - Logical right: zero fill from the MSB.
  - Arithmetic right: fill with the original din[WIDTH-1]. The sign is latched at input and carried through the stages.
  - Left logical and left arithmetic are identical: zero fill from the LSB.
  - Rotate: bits shifted out re-enter at the opposite end. Left rotate by n equals right rotate by WIDTH-n.
  - mode 11 yields the logical result; no error flag.
- Boundary conditions:
  - shamt = 0: dout = din for all modes.
  - shamt = WIDTH-1: single surviving bit (logical/arithmetic) or a full rotate minus one.
  - A simultaneous output transfer and input transfer with a full pipeline is legal. Everything advances and inflight is unchanged.
  - inflight increments on input transfer only, decrements on output transfer only, and is unchanged when both occur.
- Output holding:
  - dout/out_valid stay stable while out_valid && !out_ready.
  - dout keeps its last value after out_valid drops.
- Reset mid-operation:
  - All in-flight transactions are discarded; no output appears afterwards.
  - An input presented in the reset cycle is not accepted.

Test Plan:
- WIDTH=8, STAGE_REG=1, din=0x96, shamt=3, out_ready=1:
  - lr=0, mode=00 -> dout=0x12
  - lr=0, mode=01 -> dout=0xF2
  - lr=1, mode=00 -> dout=0xB0
  - lr=1, mode=01 -> dout=0xB0
  - lr=0, mode=10 -> dout=0xD2
  - lr=1, mode=10 -> dout=0xB4
  - Each result appears exactly 3 cycles after input transfer.
- Sweep shamt 0..7 for all modes with din=0x81 and din=0x7F:
  - Compare against a reference model; shamt=0 gives dout=din.
  - mode=11 gives results equal to mode=00.
- Stream 0x01,0x02,0x04,0x08 (lr=1, shamt=1) with out_ready=0 for 6 cycles:
  - in_ready falls after 3 accepts and inflight reaches 3.
  - After out_ready=1, outputs are 0x02,0x04,0x08,0x10 in order, one per cycle.
- Continuous input with out_ready toggling on a random 50% pattern for 1000 transactions:
  - Scoreboard shows zero loss or duplication.
  - dout stays stable during every stall.
- Assert rst with 2 transactions in flight:
  - Next cycle out_valid=0, inflight=0, dout=0x00, in_ready=1.
  - No stale result emerges.
- STAGE_REG=0, WIDTH=16, din=0x8001, shamt=15, lr=0, mode=01:
  - dout=0xFFFF with latency 1.
  - Back-to-back transactions run at full rate with out_ready=1.
